// File: rtl/mp_add_stream.sv
// mp_add_stream: streams multi-precision add/subtract operations one WIDTH-bit
// word pair per beat, least-significant word first. It carries the inter-word
// carry in a register, so each cycle needs only one WIDTH-bit addition.
// All outputs are registered. There is a single output stage and no skid
// buffer, so in_ready is combinational from out_valid and out_ready.
module mp_add_stream #(
  parameter int WIDTH = 16,
  parameter int IDXW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_first,
  output logic             out_last,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_s_q;
  logic             out_first_q;
  logic             out_last_q;
  logic [IDXW-1:0]  out_idx_q, out_idx_d;
  logic             out_cout_q;
  logic             out_ovf_q;
  logic             out_err_q;

  logic             fire;
  logic             start;
  logic             sub_eff;
  logic             cin;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             err;

  assign in_ready = !out_valid_q || out_ready;
  assign fire     = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_err   = out_err_q;

  // Word datapath. A beat seen in IDLE, or any beat flagged first, starts a
  // new operation: it takes carry-in and mode from in_sub and drops carry_q.
  always_comb begin
    start       = (state_q == IDLE) || in_first;
    sub_eff     = start ? in_sub : sub_q;
    cin         = start ? in_sub : carry_q;
    b_eff       = sub_eff ? ~in_b : in_b;
    {cout, sum} = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    ovf         = in_last && (in_a[WIDTH-1] == b_eff[WIDTH-1])
                          && (sum[WIDTH-1] != in_a[WIDTH-1]);
    // A beat in IDLE without in_first is an error. A beat in BUSY with
    // in_first is a restart and is also an error.
    err         = (state_q == IDLE) ? !in_first : in_first;
    out_idx_d   = start ? '0 : out_idx_q + {{(IDXW-1){1'b0}}, 1'b1};
    state_d     = in_last ? IDLE : BUSY;
    carry_d     = cout;
    sub_d       = sub_eff;
  end

  // Operation FSM, carry/mode registers and the registered result stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (fire) begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      out_valid_q <= 1'b1;
      out_s_q     <= sum;
      out_first_q <= start;
      out_last_q  <= in_last;
      out_idx_q   <= out_idx_d;
      out_cout_q  <= cout;
      out_ovf_q   <= ovf;
      out_err_q   <= err;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: doc/mp_add_stream.md
# mp_add_stream

Sequential multi-precision adder/subtractor that streams wide operands through the team's 16-bit carry-lookahead core, one word pair per beat, least-significant word first. It sits directly upstream of the `cla_16bits` core. It owns the operand handshake, the inter-word carry register, subtraction inversion, and the registered result stream. Wide integer datapaths (32/64/128-bit) use it without a wider combinational adder.

## Interface
- `WIDTH`, 16: word width; must match the CLA core width.
- `IDXW`, 8: width of the word-index counter.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: block can accept a beat.
- `in_a` input WIDTH: operand A word.
- `in_b` input WIDTH: operand B word.
- `in_first` input 1: beat is the least-significant word of an operation.
- `in_last` input 1: beat is the most-significant word.
- `in_sub` input 1: operation is A−B; sampled only on the first beat.
- `out_valid` output 1: result beat valid.
- `out_ready` input 1: downstream accepts the result beat.
- `out_s` output WIDTH: result word.
- `out_first` output 1: copy of the accepted beat's first flag, after the restart rule below.
- `out_last` output 1: copy of the accepted beat's last flag.
- `out_idx` output IDXW: word index within the operation; 0 on the first word.
- `out_cout` output 1: carry out of this word. On the last word it is the final carry; for subtraction, 1 means no borrow.
- `out_ovf` output 1: signed overflow. Meaningful only when `out_last`=1; 0 otherwise.
- `out_err` output 1: protocol-error flag for this beat.

## Operation
- Beat accepted ("fire") when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is a single output register with no skid buffer.
- FSM has two states.
  - IDLE: expecting the first word.
  - BUSY: inside a multi-word operation.
- IDLE, on fire:
  - The beat is treated as a first word regardless of `in_first`.
  - `out_err`=1 if `in_first`=0.
  - `sub_q` ← `in_sub`.
  - Carry-in = `in_sub`.
  - `out_idx`=0.
  - Next state: BUSY if `in_last`=0, else IDLE.
- BUSY, on fire with `in_first`=0:
  - Carry-in = `carry_q`.
  - `out_idx` = previous index + 1, wrapping modulo 2^IDXW.
  - Next state: IDLE on `in_last`, else BUSY.
- BUSY, on fire with `in_first`=1 (restart):
  - Discard `carry_q`.
  - Handle the beat exactly as an IDLE first beat.
  - `out_err`=1.
- Datapath:
  - b_eff = `sub_q`/`in_sub` ? ~`in_b` : `in_b`.
  - {Cout, S} = CLA(`in_a`, b_eff, carry-in).
  - `carry_q` ← Cout on every fire.
- `out_ovf` = (`in_a`[MSB] == b_eff[MSB]) && (S[MSB] != `in_a`[MSB]), gated by `in_last`.
- `out_first` = 1 for any beat handled as a first beat.
- Registers hold when there is no fire. Output registers hold while `out_valid && !out_ready`.
- When `out_ready`=1 and there is no fire, `out_valid` clears.
- Reset state (async, immediate):
  - FSM = IDLE; `carry_q`=0; `sub_q`=0.
  - `out_valid`=0; `out_s`=0; `out_first`=0; `out_last`=0; `out_idx`=0.
  - `out_cout`=0; `out_ovf`=0; `out_err`=0.
  - `in_ready`=1 once reset deasserts.
- Reset mid-operation abandons the partial result. The next beat is treated as a first word.

## Timing
- Latency: 1 cycle. A beat fired at edge k appears on `out_*` with `out_valid`=1 after edge k.
- Throughput: 1 word/cycle when `out_ready` stays high.
- Backpressure: `out_ready`=0 with `out_valid`=1 forces `in_ready`=0 combinationally. `out_*` stays stable until acceptance.
- On the cycle the output is accepted, a new beat may fire in the same cycle (full-rate handoff).
- The carry path is a single CLA evaluation per cycle. There is no ripple across words within a cycle.

## Test plan
- **64-bit add, LSW first.**
  - Stimulus: A words FFFF,FFFF,FFFF,7FFF; B words 0001,0000,0000,0000; `out_ready`=1.
  - Required: `out_s` 0000,0000,0000,8000; `out_idx` 0..3; final `out_cout`=0; `out_ovf`=1 on the last word only.
- **32-bit subtract.**
  - Stimulus: A=0000,0000; B=0001,0000; `in_sub`=1 on the first beat only.
  - Required: `out_s` FFFF,FFFF; `out_cout`=0 on both words (borrow); `out_ovf`=0.
- **Backpressure.**
  - Stimulus: same 4-word add; hold `out_ready`=0 for 3 cycles after word 1.
  - Required: `in_ready`=0 during the hold; word 1 output stable; word 2 sum still correct, proving the carry was preserved.
- **Restart.**
  - Stimulus: `in_first` asserted on the 3rd beat of a 4-word operation, with A=0005, B=0003.
  - Required: that beat gives `out_s`=0008, `out_idx`=0, `out_first`=1, `out_err`=1; the carry from the aborted words is not used.
- **Async reset mid-operation.**
  - Stimulus: `rst` asserted between words 2 and 3, then a single beat with `in_first`=`in_last`=1, A=FFFF, B=0001.
  - Required: all outputs go to 0 immediately on reset; the beat then gives `out_s`=0000, `out_cout`=1, `out_ovf`=0, `out_err`=0.
- **Missing first flag.**
  - Stimulus: beat in IDLE with `in_first`=0, A=0001, B=0001.
  - Required: `out_s`=0002, `out_first`=1, `out_err`=1, `out_idx`=0.
